// File: rtl/pipe_skid_reg.sv
// Two-entry skid register: main drives out_*, skid absorbs one entry while downstream stalls.
// Latency 1 cycle in_* to out_*; in_ready is registered (~skid valid), so out_ready never reaches it combinationally.
module pipe_skid_reg #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
   } ent_t;

   ent_t main_q, main_d, skid_q, skid_d, in_ent;
   logic main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
   logic accept, consume, main_free;

   assign in_ent    = {in_ctrl, in_data};
   assign in_ready  = ~skid_vld_q;
   assign accept    = in_valid & ~skid_vld_q;
   assign consume   = main_vld_q & out_ready;
   assign main_free = ~main_vld_q | consume;

   assign out_valid = main_vld_q;
   assign out_ctrl  = main_q.ctrl;
   assign out_data  = main_q.data;

   always_comb begin
      main_d     = main_q;
      skid_d     = skid_q;
      main_vld_d = main_vld_q;
      skid_vld_d = skid_vld_q;
      if (flush) begin
         main_d     = '0;
         skid_d     = '0;
         main_vld_d = 1'b0;
         skid_vld_d = 1'b0;
      end else if (main_free) begin
         if (skid_vld_q) begin
            // skid full implies in_ready=0, so no accept can refill skid here
            main_d     = skid_q;
            main_vld_d = 1'b1;
            skid_vld_d = accept;
            if (accept) skid_d = in_ent;
         end else if (accept) begin
            main_d     = in_ent;
            main_vld_d = 1'b1;
         end else begin
            main_vld_d = 1'b0;
         end
      end else if (accept) begin
         skid_d     = in_ent;
         skid_vld_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q     <= '0;
         skid_q     <= '0;
         main_vld_q <= 1'b0;
         skid_vld_q <= 1'b0;
         occupancy  <= 2'd0;
      end else begin
         main_q     <= main_d;
         skid_q     <= skid_d;
         main_vld_q <= main_vld_d;
         skid_vld_q <= skid_vld_d;
         occupancy  <= {1'b0, main_vld_d} + {1'b0, skid_vld_d};
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two widths share one stimulus stream and are checked against a queue model.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [9:0]  in_ctrl = '0;
   logic [63:0] in_data = '0;

   logic        rdy8, vld8, rdy64, vld64;
   logic [9:0]  ctrl8, ctrl64;
   logic [7:0]  data8;
   logic [63:0] data64;
   logic [1:0]  occ8, occ64;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(.DATA_W(8), .CTRL_W(10)) u8 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy8), .in_ctrl(in_ctrl), .in_data(in_data[7:0]),
      .out_valid(vld8), .out_ready(out_ready), .out_ctrl(ctrl8), .out_data(data8),
      .occupancy(occ8)
   );

   pipe_skid_reg #(.DATA_W(64), .CTRL_W(10)) u64 (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(vld64), .out_ready(out_ready), .out_ctrl(ctrl64), .out_data(data64),
      .occupancy(occ64)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   // Model: a FIFO of at most two entries; the visible payload is the head,
   // or the last head seen once the FIFO has drained (zero after flush/reset).
   typedef struct {
      logic [9:0]  c;
      logic [63:0] d;
   } ent_t;

   ent_t q[$];
   ent_t shown = '{c: 10'd0, d: 64'd0};

   always @(posedge clk or negedge rst_n) begin
      bit acc, con;
      if (!rst_n || flush) begin
         q.delete();
         shown = '{c: 10'd0, d: 64'd0};
      end else begin
         acc = in_valid && (q.size() < 2);
         con = (q.size() > 0) && out_ready;
         if (con) void'(q.pop_front());
         if (acc) q.push_back('{c: in_ctrl, d: in_data});
         if (q.size() > 0) shown = q[0];
      end
   end

   always @(negedge clk) begin
      chk("vld64",  64'(vld64),  64'(q.size() > 0));
      chk("rdy64",  64'(rdy64),  64'(q.size() < 2));
      chk("occ64",  64'(occ64),  64'(q.size()));
      chk("data64", data64,      shown.d);
      chk("ctrl64", 64'(ctrl64), 64'(shown.c));
      chk("vld8",   64'(vld8),   64'(q.size() > 0));
      chk("rdy8",   64'(rdy8),   64'(q.size() < 2));
      chk("occ8",   64'(occ8),   64'(q.size()));
      chk("data8",  64'(data8),  64'(shown.d[7:0]));
      chk("ctrl8",  64'(ctrl8),  64'(shown.c));
   end

   task automatic drive(input bit v, input bit r, input logic [63:0] d, input bit f);
      in_valid  = v;
      out_ready = r;
      in_data   = d;
      in_ctrl   = d[9:0] ^ 10'h155;
      flush     = f;
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      drive(0, 0, 64'd0, 0);
      cyc();
      chk("rst_vld",  64'(vld64), 64'd0);
      chk("rst_occ",  64'(occ64), 64'd0);
      chk("rst_rdy",  64'(rdy64), 64'd1);
      chk("rst_data", data64,     64'd0);
      chk("rst_ctrl", 64'(ctrl64), 64'd0);
      cyc();
      rst_n = 1'b1;

      // streaming: one entry per cycle, occupancy steady at 1
      for (int k = 1; k <= 8; k++) begin
         drive(1, 1, 64'(k), 0);
         cyc();
         chk("stream_data", data64,      64'(k));
         chk("stream_vld",  64'(vld64),  64'd1);
         chk("stream_occ",  64'(occ64),  64'd1);
         chk("stream_rdy",  64'(rdy64),  64'd1);
         chk("stream_ctrl", 64'(ctrl64), 64'(10'(k) ^ 10'h155));
      end
      drive(0, 1, 64'd0, 0);
      cyc();
      chk("stream_empty", 64'(vld64), 64'd0);

      // stall fill
      drive(1, 0, 64'hA5, 0);
      cyc();
      chk("fill1_occ",  64'(occ64), 64'd1);
      chk("fill1_data", data64,     64'hA5);
      chk("fill1_rdy",  64'(rdy64), 64'd1);
      drive(1, 0, 64'h5A, 0);
      cyc();
      chk("fill2_occ",  64'(occ64), 64'd2);
      chk("fill2_rdy",  64'(rdy64), 64'd0);
      chk("fill2_data", data64,     64'hA5);
      drive(1, 0, 64'h77, 0);
      cyc();
      chk("fill3_occ",  64'(occ64), 64'd2);
      chk("fill3_data", data64,     64'hA5);
      chk("fill3_vld",  64'(vld64), 64'd1);

      // drain
      drive(0, 1, 64'd0, 0);
      cyc();
      chk("drain1_data", data64,     64'h5A);
      chk("drain1_occ",  64'(occ64), 64'd1);
      cyc();
      chk("drain2_vld", 64'(vld64), 64'd0);
      chk("drain2_occ", 64'(occ64), 64'd0);
      chk("drain2_rdy", 64'(rdy64), 64'd1);

      // flush with a full buffer and a concurrent input
      drive(1, 0, 64'h11, 0);
      cyc();
      drive(1, 0, 64'h22, 0);
      cyc();
      chk("pre_flush_occ", 64'(occ64), 64'd2);
      drive(1, 1, 64'h99, 1);
      #1;
      chk("flush_rdy_during", 64'(rdy64), 64'd0);
      cyc();
      chk("flush_vld",  64'(vld64),  64'd0);
      chk("flush_ctrl", 64'(ctrl64), 64'd0);
      chk("flush_data", data64,      64'd0);
      chk("flush_occ",  64'(occ64),  64'd0);
      chk("flush_rdy",  64'(rdy64),  64'd1);
      drive(0, 1, 64'd0, 0);
      cyc();
      chk("flush_no_ghost", 64'(vld64), 64'd0);

      // asynchronous reset mid-operation
      drive(1, 0, 64'h44, 0);
      cyc();
      drive(1, 0, 64'h55, 0);
      cyc();
      chk("pre_rst_occ", 64'(occ64), 64'd2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_vld",  64'(vld64), 64'd0);
      chk("arst_occ",  64'(occ64), 64'd0);
      chk("arst_data", data64,     64'd0);
      chk("arst_rdy",  64'(rdy64), 64'd1);
      cyc();
      rst_n = 1'b1;
      drive(1, 1, 64'h33, 0);
      cyc();
      chk("post_rst_vld",  64'(vld64), 64'd1);
      chk("post_rst_data", data64,     64'h33);
      drive(0, 1, 64'd0, 0);
      cyc();

      // random traffic at 50% valid/ready with occasional flush
      for (int i = 0; i < 10000; i++) begin
         drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
               {$urandom, $urandom}, $urandom_range(0, 127) == 0);
         cyc();
      end
      drive(0, 1, 64'd0, 0);
      cyc();
      cyc();
      chk("final_empty", 64'(vld64), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
